joint_ramp_ctrl: RTL and testbench

//   Sequences one joint_pwmdir channel: owns its jointEnable and jointFreqCmd inputs.

---
 rtl/joint_pkg.sv | 26 ++
 rtl/joint_ramp_ctrl_if.sv | 24 ++
 rtl/joint_ramp_slew.sv | 42 ++++
 rtl/joint_ramp_ctrl.sv | 170 +++++++++++++++++
 tb/tb_joint_ramp_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/joint_pkg.sv
// Shared types, state encoding and frequency saturation helper for the joint ramp controller.
package joint_pkg;

  localparam int unsigned JOINT_W = 32;

  typedef logic signed [JOINT_W-1:0] freq_t;
  typedef logic [1:0]                joint_state_t;

  localparam joint_state_t ST_OFF   = 2'd0;
  localparam joint_state_t ST_RUN   = 2'd1;
  localparam joint_state_t ST_STOP  = 2'd2;
  localparam joint_state_t ST_FAULT = 2'd3;

  // Clamp a signed frequency to +/-lim (lim assumed non-negative).
  function automatic freq_t sat_freq(input freq_t x, input freq_t lim);
    freq_t r;
    r = x;
    if (x > lim) begin
      r = lim;
    end else if (x < -lim) begin
      r = -lim;
    end
    return r;
  endfunction

endpackage

// File: rtl/joint_ramp_ctrl_if.sv
// Host-side command/status bundle between the register interface and joint_ramp_ctrl.
interface joint_ramp_ctrl_if;
  import joint_pkg::*;

  logic         enableReq;
  freq_t        freqTarget;
  logic         cmdStrobe;
  logic         jointEnable;
  freq_t        jointFreqCmd;
  logic         atTarget;
  joint_state_t state;
  logic         wdtFault;

  modport master (
    output enableReq, freqTarget, cmdStrobe,
    input  jointEnable, jointFreqCmd, atTarget, state, wdtFault
  );

  modport slave (
    input  enableReq, freqTarget, cmdStrobe,
    output jointEnable, jointFreqCmd, atTarget, state, wdtFault
  );

endinterface

// File: rtl/joint_ramp_slew.sv
// Tick-gated, acceleration-limited step of the frequency command toward the effective target.
module joint_ramp_slew
  import joint_pkg::*;
#(
  parameter logic [JOINT_W-1:0] ACCEL_STEP = 32'd16
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  input  logic  en,
  input  freq_t eff,
  output freq_t cmd
);

  localparam int unsigned DW = JOINT_W + 1;
  localparam logic signed [DW-1:0] STEP_S = $signed({1'b0, ACCEL_STEP});

  logic signed [DW-1:0] diff;
  freq_t                cmd_nxt;

  // Difference is taken one bit wider so opposite-sign extremes cannot wrap.
  always_comb begin
    diff    = $signed({eff[JOINT_W-1], eff}) - $signed({cmd[JOINT_W-1], cmd});
    cmd_nxt = eff;
    if (diff > STEP_S) begin
      cmd_nxt = cmd + $signed(ACCEL_STEP);
    end else if (diff < -STEP_S) begin
      cmd_nxt = cmd - $signed(ACCEL_STEP);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd <= '0;
    end else if (!en) begin
      cmd <= '0;
    end else if (tick) begin
      cmd <= cmd_nxt;
    end
  end

endmodule

// File: rtl/joint_ramp_ctrl.sv
// Enable/stop sequencer and frequency ramp for one joint_pwmdir channel.
// Optional host-command watchdog compiled in with JOINT_RAMP_WDT_EN.
module joint_ramp_ctrl
  import joint_pkg::*;
#(
  parameter int unsigned        TICK_DIV   = 48000,
  parameter logic [JOINT_W-1:0] ACCEL_STEP = 32'd16,
  parameter logic [JOINT_W-1:0] FREQ_MAX   = 32'd2000000,
  parameter int unsigned        WDT_TICKS  = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  joint_ramp_ctrl_if.slave   bus
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  freq_t             target_q;
  freq_t             cmd;
  freq_t             eff;
  joint_state_t      state_q;
  joint_state_t      state_nxt;
  logic              enable_q;
  logic              enable_nxt;
  logic              slew_en;
  logic              wdt_expire;
  logic              wdt_fault;

  // Free-running ramp update tick.
  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // Host target is latched in every state; only RUN consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_q <= '0;
    end else if (bus.cmdStrobe) begin
      target_q <= sat_freq(bus.freqTarget, freq_t'(FREQ_MAX));
    end
  end

`ifdef JOINT_RAMP_WDT_EN
  localparam int unsigned WDT_W = $clog2(WDT_TICKS + 1);

  logic [WDT_W-1:0] wdt_cnt;
  logic             wdt_fault_q;

  // Expiry is judged on the tick alone, so a coincident strobe cannot rescue it.
  assign wdt_expire = (state_q == ST_RUN) && tick && (wdt_cnt == WDT_W'(WDT_TICKS - 1));
  assign wdt_fault  = wdt_fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
    end else if ((state_q != ST_RUN) || bus.cmdStrobe) begin
      wdt_cnt <= '0;
    end else if (tick) begin
      wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdt_fault_q <= 1'b0;
    end else if (wdt_expire) begin
      wdt_fault_q <= 1'b1;
    end else if ((state_q == ST_FAULT) && !bus.enableReq) begin
      wdt_fault_q <= 1'b0;
    end
  end
`else
  logic unused_wdt_cfg;

  assign unused_wdt_cfg = |WDT_TICKS;
  assign wdt_expire     = 1'b0;
  assign wdt_fault      = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_OFF: begin
        if (bus.enableReq && !wdt_fault) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (wdt_expire || !bus.enableReq) begin
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bus.enableReq && !wdt_fault) begin
          state_nxt = ST_RUN;
        end else if (cmd == '0) begin
          state_nxt = wdt_fault ? ST_FAULT : ST_OFF;
        end
      end
      ST_FAULT: begin
        if (!bus.enableReq) begin
          state_nxt = ST_OFF;
        end
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // Output decode: effective target and slew gating follow the current state.
  always_comb begin
    eff        = '0;
    slew_en    = 1'b0;
    enable_nxt = 1'b0;
    if (state_q == ST_RUN) begin
      eff = target_q;
    end
    if ((state_q == ST_RUN) || (state_q == ST_STOP)) begin
      slew_en = 1'b1;
    end
    if ((state_nxt == ST_RUN) || (state_nxt == ST_STOP)) begin
      enable_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable_nxt;
    end
  end

  joint_ramp_slew #(
    .ACCEL_STEP (ACCEL_STEP)
  ) u_slew (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .en    (slew_en),
    .eff   (eff),
    .cmd   (cmd)
  );

  assign bus.jointEnable  = enable_q;
  assign bus.jointFreqCmd = cmd;
  assign bus.atTarget     = (cmd == eff);
  assign bus.state        = state_q;
  assign bus.wdtFault     = wdt_fault;

endmodule

// File: tb/tb_joint_ramp_ctrl.sv
// Directed scoreboard bench for joint_ramp_ctrl; watchdog scenarios follow JOINT_RAMP_WDT_EN.
module tb_joint_ramp_ctrl;
  import joint_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  joint_ramp_ctrl_if bus ();

  joint_ramp_ctrl #(
    .TICK_DIV   (4),
    .ACCEL_STEP (32'd100),
    .FREQ_MAX   (32'd1000),
    .WDT_TICKS  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    compared   = 0;
  int    mismatched = 0;
  freq_t sb[$];
  freq_t prev_cmd   = '0;
  logic signed [32:0] mon_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Every change of the command must be the next expected value and a legal step.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cmd = '0;
    end else if (bus.jointFreqCmd !== prev_cmd) begin
      mon_d = $signed({bus.jointFreqCmd[31], bus.jointFreqCmd}) - $signed({prev_cmd[31], prev_cmd});
      check("cmd_step_le_accel", 32'((mon_d <= 33'sd100) && (mon_d >= -33'sd100)), 32'd1);
      if (sb.size() == 0) check("cmd_unexpected_change", bus.jointFreqCmd, prev_cmd);
      else check("cmd_seq", bus.jointFreqCmd, sb.pop_front());
      prev_cmd = bus.jointFreqCmd;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic strobe(input int v);
    bus.freqTarget = freq_t'(v);
    bus.cmdStrobe  = 1'b1;
    step();
    bus.cmdStrobe  = 1'b0;
  endtask

  // Reference slew model: 100 per tick, final partial step lands on target.
  task automatic push_ramp(input int from, input int to);
    int cur;
    cur = from;
    while (cur != to) begin
      if ((to - cur <= 100) && (cur - to <= 100)) cur = to;
      else if (to > cur) cur = cur + 100;
      else cur = cur - 100;
      sb.push_back(freq_t'(cur));
    end
  endtask

  task automatic drain(input string tag, input bit keep, input int keep_val, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0) && (n < budget)) begin
      if (keep && (n % 8 == 7)) strobe(keep_val);
      else step();
      n++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    bus.enableReq  = 1'b0;
    bus.freqTarget = '0;
    bus.cmdStrobe  = 1'b0;
    repeat (3) step();
    check("rst_state",  32'(bus.state), 32'd0);
    check("rst_enable", 32'(bus.jointEnable), 32'd0);
    check("rst_cmd",    bus.jointFreqCmd, 32'd0);
    check("rst_attgt",  32'(bus.atTarget), 32'd1);
    check("rst_wdt",    32'(bus.wdtFault), 32'd0);
    rst_n = 1'b1;
    step();

    // Reset mid-ramp
    bus.enableReq = 1'b1;
    sb.push_back(32'sd100); sb.push_back(32'sd200); sb.push_back(32'sd300);
    strobe(1000);
    drain("t1", 1'b1, 1000, 60);
    check("t1_cmd300",  bus.jointFreqCmd, 32'd300);
    check("t1_attgt0",  32'(bus.atTarget), 32'd0);
    rst_n = 1'b0;
    #1;
    check("t1_async_cmd",    bus.jointFreqCmd, 32'd0);
    check("t1_async_enable", 32'(bus.jointEnable), 32'd0);
    check("t1_async_state",  32'(bus.state), 32'd0);
    sb.delete();
    bus.enableReq = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Enable and ramp to 450
    bus.enableReq = 1'b1;
    sb.push_back(32'sd100); sb.push_back(32'sd200); sb.push_back(32'sd300);
    sb.push_back(32'sd400); sb.push_back(32'sd450);
    strobe(450);
    check("t2_enable_next", 32'(bus.jointEnable), 32'd1);
    check("t2_state_run",   32'(bus.state), 32'd1);
    drain("t2", 1'b1, 450, 80);
    check("t2_cmd",   bus.jointFreqCmd, 32'd450);
    check("t2_attgt", 32'(bus.atTarget), 32'd1);

    // Sign reversal through zero
    sb.push_back(32'sd350); sb.push_back(32'sd250); sb.push_back(32'sd150);
    sb.push_back(32'sd50);  sb.push_back(-32'sd50); sb.push_back(-32'sd150);
    sb.push_back(-32'sd250);
    strobe(-250);
    drain("t3", 1'b1, -250, 80);
    check("t3_cmd",   bus.jointFreqCmd, 32'hFFFF_FF06);
    check("t3_attgt", 32'(bus.atTarget), 32'd1);

    // Saturating target
    push_ramp(-250, 1000);
    strobe(5000);
    drain("t4", 1'b1, 5000, 200);
    repeat (12) step();
    check("t4_cmd_sat", bus.jointFreqCmd, 32'd1000);
    check("t4_attgt",   32'(bus.atTarget), 32'd1);

    // Disable at 250, ramp down to OFF
    push_ramp(1000, 250);
    strobe(250);
    drain("t5a", 1'b1, 250, 120);
    check("t5_cmd250", bus.jointFreqCmd, 32'd250);
    bus.enableReq = 1'b0;
    sb.push_back(32'sd150); sb.push_back(32'sd50); sb.push_back(32'sd0);
    step();
    check("t5_state_stop", 32'(bus.state), 32'd2);
    drain("t5b", 1'b0, 0, 40);
    check("t5_state_at0",  32'(bus.state), 32'd2);
    check("t5_enable_at0", 32'(bus.jointEnable), 32'd1);
    step();
    check("t5_state_off",   32'(bus.state), 32'd0);
    check("t5_enable_drop", 32'(bus.jointEnable), 32'd0);

`ifdef JOINT_RAMP_WDT_EN
    // Watchdog expiry, fault latch and clear
    bus.enableReq = 1'b1;
    sb.push_back(32'sd100); sb.push_back(32'sd200); sb.push_back(32'sd300);
    strobe(300);
    drain("t6a", 1'b0, 0, 40);
    check("t6_no_early_fault", 32'(bus.wdtFault), 32'd0);
    for (int n = 0; (n < 60) && (bus.wdtFault !== 1'b1); n++) step();
    check("t6_wdt_fault", 32'(bus.wdtFault), 32'd1);
    check("t6_state_stop", 32'(bus.state), 32'd2);
    sb.push_back(32'sd200); sb.push_back(32'sd100); sb.push_back(32'sd0);
    drain("t6b", 1'b0, 0, 40);
    check("t6_state_at0", 32'(bus.state), 32'd2);
    step();
    check("t6_state_fault",  32'(bus.state), 32'd3);
    check("t6_enable_drop",  32'(bus.jointEnable), 32'd0);
    repeat (8) step();
    check("t6_fault_holds",  32'(bus.state), 32'd3);
    check("t6_fault_cmd0",   bus.jointFreqCmd, 32'd0);
    check("t6_fault_latched", 32'(bus.wdtFault), 32'd1);
    bus.enableReq = 1'b0;
    step();
    check("t6_state_off",  32'(bus.state), 32'd0);
    check("t6_fault_clr",  32'(bus.wdtFault), 32'd0);
`else
    // No watchdog: long silence in RUN stays in RUN
    bus.enableReq = 1'b1;
    sb.push_back(32'sd100); sb.push_back(32'sd200); sb.push_back(32'sd300);
    strobe(300);
    drain("t6a", 1'b0, 0, 40);
    repeat (440) step();
    check("t6_no_fault", 32'(bus.wdtFault), 32'd0);
    check("t6_run",      32'(bus.state), 32'd1);
    check("t6_enable",   32'(bus.jointEnable), 32'd1);
    bus.enableReq = 1'b0;
    sb.push_back(32'sd200); sb.push_back(32'sd100); sb.push_back(32'sd0);
    drain("t6b", 1'b0, 0, 40);
    step();
    check("t6_state_off", 32'(bus.state), 32'd0);
`endif

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
